// File: rtl/srl16_chk_sequencer.sv
// Self-checking sequencer for parallel SRL16 lanes: drives an LFSR stream into every lane,
// keeps a bit-exact shadow of each lane and latches sticky per-lane tap mismatches.
module srl16_chk_sequencer #(
    parameter int unsigned NUM_SRL   = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned RUN_LEN   = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               srl_ce,
    output logic [NUM_SRL-1:0] srl_d,
    output logic [3:0]         srl_a,
    input  logic [NUM_SRL-1:0] srl_q,
    output logic [NUM_SRL-1:0] error,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SHIFT,
        READ,
        DONE
    } state_t;

    localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] POLY     = 16'hB400;
    localparam logic [16:0] LAST_CNT = 17'(RUN_LEN);

    state_t             state;
    state_t             state_next;
    logic [3:0]         fill_cnt;
    logic [3:0]         addr;
    logic [3:0]         tap;
    logic [15:0]        pairs;
    logic [15:0]        lfsr;
    logic [15:0]        lfsr_next;
    logic [NUM_SRL-1:0] err_q;
    logic [15:0]        hist [NUM_SRL];
    logic               shift_en;
    logic               pairs_last;

    assign shift_en   = (state == FILL) || (state == SHIFT);
    assign pairs_last = ({1'b0, pairs} + 17'd1) == LAST_CNT;
    assign lfsr_next  = lfsr[0] ? ((lfsr >> 1) ^ POLY) : (lfsr >> 1);

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FILL;
            FILL:    if (fill_cnt == 4'd15) state_next = SHIFT;
            SHIFT:   state_next = READ;
            READ:    state_next = pairs_last ? DONE : SHIFT;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fill_cnt <= 4'd0;
            addr     <= 4'd0;
            tap      <= 4'd0;
            pairs    <= 16'd0;
            lfsr     <= SEED;
            err_q    <= '0;
            // NOTE: the shadow array is reset on purpose; a restart must compare against a known history.
            for (int i = 0; i < NUM_SRL; i++) begin
                hist[i] <= 16'd0;
            end
        end else begin
            state <= state_next;
            if (state == FILL) begin
                fill_cnt <= fill_cnt + 4'd1;
            end
            if (shift_en) begin
                lfsr <= lfsr_next;
                for (int i = 0; i < NUM_SRL; i++) begin
                    hist[i] <= {hist[i][14:0], lfsr[i]};
                end
            end
            // The tap address moves only at the SHIFT->READ edge, giving srl_q a full settling cycle.
            if (state == SHIFT) begin
                tap <= addr;
            end
            if (state == READ) begin
                for (int i = 0; i < NUM_SRL; i++) begin
                    err_q[i] <= err_q[i] | (srl_q[i] != hist[i][tap]);
                end
                addr  <= addr + 4'd1;
                pairs <= pairs + 16'd1;
            end
        end
    end

    assign srl_ce = shift_en;
    assign srl_d  = shift_en ? lfsr[NUM_SRL-1:0] : '0;
    assign srl_a  = tap;
    assign error  = err_q;
    assign busy   = (state == FILL) || (state == SHIFT) || (state == READ);
    assign done   = (state == DONE);

endmodule

// File: tb/tb_srl16_chk_sequencer.sv
// Bench for srl16_chk_sequencer: behavioural SRL16 lanes with injectable faults and a
// cycle-numbered reference model; srl_d words go through a scoreboard queue.
module tb_srl16_chk_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0;
    logic       start_w = 1'b0;
    int         fault = 0;
    bit         sel = 1'b0;
    int         errors = 0;
    int         checks = 0;

    logic       ce_a, ce_w, busy_a, busy_w, done_a, done_w;
    logic [7:0] d_a, d_w, q_a, q_w, err_a, err_w;
    logic [3:0] a_a, a_w;
    logic [15:0] mem_a [8];
    logic [15:0] mem_w [8];

    logic       obs_ce, obs_busy, obs_done;
    logic [7:0] obs_d, obs_err;
    logic [3:0] obs_a;

    always #5 clk = ~clk;

    srl16_chk_sequencer #(.NUM_SRL(8), .LFSR_SEED(16'hACE1), .RUN_LEN(256)) dut (
        .clk(clk), .rst(rst), .start(start_a), .srl_ce(ce_a), .srl_d(d_a), .srl_a(a_a),
        .srl_q(q_a), .error(err_a), .busy(busy_a), .done(done_a)
    );

    srl16_chk_sequencer #(.NUM_SRL(8), .LFSR_SEED(16'hACE1), .RUN_LEN(20)) dut_wrap (
        .clk(clk), .rst(rst), .start(start_w), .srl_ce(ce_w), .srl_d(d_w), .srl_a(a_w),
        .srl_q(q_w), .error(err_w), .busy(busy_w), .done(done_w)
    );

    // Behavioural SRL16 lanes; contents are never reset, like the real primitive.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (ce_a) mem_a[i] <= {mem_a[i][14:0], d_a[i]};
            if (ce_w) mem_w[i] <= {mem_w[i][14:0], d_w[i]};
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            q_a[i] = mem_a[i][a_a];
            q_w[i] = mem_w[i][a_w];
        end
        if (fault == 1) q_a[3] = 1'b0;
        if (fault == 2) q_a[0] = mem_a[0][4'(a_a + 4'd1)];
        if (fault == 3) q_a[5] = ~mem_a[5][a_a];
    end

    always_comb begin
        obs_ce   = sel ? ce_w   : ce_a;
        obs_busy = sel ? busy_w : busy_a;
        obs_done = sel ? done_w : done_a;
        obs_d    = sel ? d_w    : d_a;
        obs_err  = sel ? err_w  : err_a;
        obs_a    = sel ? a_w    : a_a;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start_a = 1'b0;
        start_w = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if ({obs_ce, obs_busy, obs_done, obs_d, obs_a, obs_err} !== 23'd0) begin
            errors++;
            $display("FAIL %s idle outputs got ce=%b busy=%b done=%b d=%h a=%h err=%h exp all 0",
                     tag, obs_ce, obs_busy, obs_done, obs_d, obs_a, obs_err);
        end
    endtask

    // Runs one sequence from the start pulse. abort_at >= 0 pulses rst at that cycle.
    task automatic run(input bit use_w, input int run_len, input int flt, input int abort_at,
                       input bit pokes, input int extra, input bit chk_final, input logic [7:0] final_err);
        logic [15:0] lf;
        logic [15:0] hist [8];
        logic [7:0]  exp_err;
        logic [7:0]  exp_q [$];
        logic [7:0]  exp_d;
        logic        q_pred;
        int          ce_cnt, done_t, last, k;
        bit          fill, shift, read, e_ce, e_busy, e_done, st;
        logic [3:0]  e_a;

        sel = use_w;
        fault = flt;
        lf = 16'hACE1;
        for (int i = 0; i < 8; i++) hist[i] = 16'd0;
        exp_err = 8'd0;
        ce_cnt = 0;
        done_t = 17 + 2 * run_len;
        last = done_t + extra;
        @(negedge clk);
        for (int t = 0; t <= last; t++) begin
            if (t > 0) @(negedge clk);
            fill   = (t >= 1) && (t <= 16);
            shift  = (t >= 17) && (t < done_t) && (t % 2 == 1);
            read   = (t >= 18) && (t < done_t) && (t % 2 == 0);
            e_ce   = fill || shift;
            e_busy = (t >= 1) && (t < done_t);
            e_done = (t >= done_t);

            checks++;
            if (obs_ce !== e_ce) begin
                errors++;
                $display("FAIL srl_ce t=%0d got=%b exp=%b", t, obs_ce, e_ce);
            end
            checks++;
            if ({obs_busy, obs_done} !== {e_busy, e_done}) begin
                errors++;
                $display("FAIL busy_done t=%0d got=%b%b exp=%b%b", t, obs_busy, obs_done, e_busy, e_done);
            end
            checks++;
            if (obs_err !== exp_err) begin
                errors++;
                $display("FAIL error t=%0d got=%h exp=%h", t, obs_err, exp_err);
            end
            if (flt == 2 && t == 49) begin
                checks++;
                if (obs_err[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL off_by_one_within_16 t=%0d got=%b exp=1", t, obs_err[0]);
                end
            end

            if (e_ce) exp_q.push_back(lf[7:0]);
            checks++;
            if (obs_ce) begin
                ce_cnt++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL srl_d_unexpected t=%0d got=%h exp=none", t, obs_d);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (obs_d !== exp_d) begin
                        errors++;
                        $display("FAIL srl_d t=%0d got=%h exp=%h", t, obs_d, exp_d);
                    end
                end
            end else if (obs_d !== 8'd0) begin
                errors++;
                $display("FAIL srl_d_idle t=%0d got=%h exp=00", t, obs_d);
            end

            if (t < done_t) begin
                if (read) e_a = 4'((t - 18) / 2);
                else if (t >= 19) e_a = 4'((t - 19) / 2);
                else e_a = 4'd0;
                checks++;
                if (obs_a !== e_a) begin
                    errors++;
                    $display("FAIL srl_a t=%0d got=%h exp=%h", t, obs_a, e_a);
                end
            end

            if (read) begin
                k = (t - 18) / 2;
                e_a = 4'(k);
                for (int i = 0; i < 8; i++) begin
                    q_pred = hist[i][e_a];
                    if (!use_w && flt == 1 && i == 3) q_pred = 1'b0;
                    if (!use_w && flt == 2 && i == 0) q_pred = hist[0][4'(e_a + 4'd1)];
                    if (!use_w && flt == 3 && i == 5) q_pred = ~hist[5][e_a];
                    if (q_pred != hist[i][e_a]) exp_err[i] = 1'b1;
                end
            end
            if (e_ce) begin
                for (int i = 0; i < 8; i++) hist[i] = {hist[i][14:0], lf[i]};
                lf = lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
            end

            st = (t == 0);
            if (pokes) st = st || (t == 5) || (t == 100) || (t == done_t + 3) || (t >= done_t + 6);
            if (use_w) start_w = st; else start_a = st;

            if (t == abort_at) begin
                start_a = 1'b0;
                start_w = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_idle("after_mid_reset");
                return;
            end
        end
        start_a = 1'b0;
        start_w = 1'b0;
        checks++;
        if (ce_cnt != 16 + run_len || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ce_count got=%0d exp=%0d pending=%0d", ce_cnt, 16 + run_len, exp_q.size());
        end
        if (chk_final) begin
            checks++;
            if (obs_err !== final_err) begin
                errors++;
                $display("FAIL final_error got=%h exp=%h", obs_err, final_err);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        sel = 1'b0;
        check_idle("reset_main");
        sel = 1'b1;
        check_idle("reset_wrap");
        rst = 1'b0;
    endtask

    task automatic test_ideal();
        do_reset();
        run(1'b0, 256, 0, -1, 1'b0, 4, 1'b1, 8'h00);
    endtask

    task automatic test_stuck_lane3();
        do_reset();
        run(1'b0, 256, 1, -1, 1'b0, 4, 1'b1, 8'h08);
    endtask

    task automatic test_off_by_one();
        do_reset();
        run(1'b0, 256, 2, -1, 1'b0, 4, 1'b1, 8'h01);
    endtask

    task automatic test_addr_wrap();
        do_reset();
        run(1'b1, 20, 0, -1, 1'b0, 4, 1'b1, 8'h00);
    endtask

    task automatic test_reset_mid_check();
        do_reset();
        run(1'b0, 256, 3, 200, 1'b0, 0, 1'b0, 8'h00);
        repeat (3) begin
            @(negedge clk);
            check_idle("idle_after_reset");
        end
        run(1'b0, 256, 0, -1, 1'b0, 4, 1'b1, 8'h00);
    endtask

    task automatic test_start_ignored();
        do_reset();
        run(1'b0, 256, 0, -1, 1'b1, 12, 1'b1, 8'h00);
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_stuck_lane3();
        test_off_by_one();
        test_addr_wrap();
        test_reset_mid_check();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
